// File: rtl/fetch_stall_ctrl.sv
// Front-end sequencer: drives PC write/stall/next-PC and IF/ID, ID/EX
// write/flush controls. Arbitrates D-cache freezes, taken-branch redirects,
// I-cache misses (with a level refill request to memory) and load-use stalls.
//
// Handshake: refill_req is a level request that rises in MISS_REQ and stays
// high through MISS_WAIT until the cycle refill_ack (a 1-cycle pulse) is seen;
// in that ack cycle refill_req is already low and the FSM returns to FETCH.
// An ack outside MISS_WAIT (e.g. a late ack after reset) is ignored.
module fetch_stall_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              icache_hit,
  input  logic              refill_ack,
  input  logic              dcache_stall,
  input  logic              load_use,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              pc_write,
  output logic              pc_stall,
  output logic [ADDR_W-1:0] pc_next,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              refill_req,
  output logic [ADDR_W-1:0] refill_addr,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                redirect_pend_q, redirect_pend_d;
  logic [ADDR_W-1:0]   redirect_addr_q, redirect_addr_d;
  logic [ADDR_W-1:0]   refill_addr_q, refill_addr_d;
  logic [CNT_W-1:0]    miss_cnt_q, stall_cnt_q;
  logic                miss_inc;
  logic                branch_ok;

  // A branch is only acted on when the pipeline is not frozen; otherwise EX holds it.
  assign branch_ok = branch_taken && !dcache_stall;

  // Next-state and combinational front-end controls.
  always_comb begin
    state_d         = state_q;
    redirect_pend_d = redirect_pend_q;
    redirect_addr_d = redirect_addr_q;
    refill_addr_d   = refill_addr_q;
    pc_write        = 1'b0;
    pc_next         = pc_cur;
    ifid_write      = 1'b0;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    refill_req      = 1'b0;
    miss_inc        = 1'b0;
    if (rst) begin
      pc_next = '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (dcache_stall) begin
            // full freeze: hold PC and IF/ID, no bubbles
          end else if (branch_taken) begin
            pc_write   = 1'b1;
            pc_next    = branch_target;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (!icache_hit) begin
            ifid_flush    = 1'b1;
            state_d       = MISS_REQ;
            refill_addr_d = {pc_cur[ADDR_W-1:4], 4'b0000};
            miss_inc      = 1'b1;
          end else if (load_use) begin
            idex_flush = 1'b1;
          end else begin
            pc_write   = 1'b1;
            pc_next    = pc_cur + ADDR_W'(4);
            ifid_write = 1'b1;
          end
        end
        MISS_REQ: begin
          refill_req = 1'b1;
          ifid_flush = 1'b1;
          state_d    = MISS_WAIT;
          if (branch_ok) begin
            idex_flush      = 1'b1;
            redirect_pend_d = 1'b1;
            redirect_addr_d = branch_target;
          end
        end
        MISS_WAIT: begin
          ifid_flush = 1'b1;
          if (refill_ack) begin
            state_d         = FETCH;
            redirect_pend_d = 1'b0;
            if (branch_ok) begin
              // a branch resolving in the ack cycle is the youngest redirect
              idex_flush = 1'b1;
              pc_write   = 1'b1;
              pc_next    = branch_target;
            end else if (redirect_pend_q) begin
              pc_write = 1'b1;
              pc_next  = redirect_addr_q;
            end
          end else begin
            refill_req = 1'b1;
            if (branch_ok) begin
              idex_flush      = 1'b1;
              redirect_pend_d = 1'b1;
              redirect_addr_d = branch_target;
            end
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign pc_stall    = !pc_write;
  assign refill_addr = refill_addr_q;
  assign miss_cnt    = miss_cnt_q;
  assign stall_cnt   = stall_cnt_q;
  assign state_dbg   = state_q;

  // State, redirect, refill address and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= FETCH;
      redirect_pend_q <= 1'b0;
      redirect_addr_q <= '0;
      refill_addr_q   <= '0;
      miss_cnt_q      <= '0;
      stall_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      redirect_pend_q <= redirect_pend_d;
      redirect_addr_q <= redirect_addr_d;
      refill_addr_q   <= refill_addr_d;
      if (miss_inc && (miss_cnt_q != {CNT_W{1'b1}}))
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Bench for fetch_stall_ctrl: directed scenarios with literal expectations,
// then randomized stimulus; a behavioural model checks every cycle at negedge.
module tb_fetch_stall_ctrl;

  localparam int AW  = 32;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc_cur, branch_target;
  logic          icache_hit, refill_ack, dcache_stall, load_use, branch_taken;
  logic          pc_write, pc_stall, ifid_write, ifid_flush, idex_flush, refill_req;
  logic [AW-1:0] pc_next, refill_addr;
  logic [CW-1:0] miss_cnt, stall_cnt;
  logic [1:0]    state_dbg;

  int n_vec = 0;
  int n_err = 0;

  fetch_stall_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .icache_hit(icache_hit),
    .refill_ack(refill_ack), .dcache_stall(dcache_stall), .load_use(load_use),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc_write(pc_write), .pc_stall(pc_stall), .pc_next(pc_next),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .refill_req(refill_req), .refill_addr(refill_addr),
    .miss_cnt(miss_cnt), .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_in_miss = 0;   // a refill is outstanding
  int            m_age     = 0;   // cycles spent since the refill started
  logic [AW-1:0] m_line    = '0;
  int            m_miss    = 0;
  int            m_stall   = 0;
  logic [AW-1:0] redir_q[$];      // redirects seen during the miss; newest wins

  always @(negedge clk) begin
    logic          e_pw, e_ifw, e_iff, e_ief, e_req, chk_ifw, start, finish;
    logic [AW-1:0] e_next;
    bit            br_ok;
    e_pw = 0; e_ifw = 0; e_iff = 0; e_ief = 0; e_req = 0;
    chk_ifw = 1; start = 0; finish = 0; e_next = '0;
    br_ok = branch_taken && !dcache_stall;

    chk("miss_cnt", AW'(miss_cnt), AW'(m_miss));
    chk("stall_cnt", AW'(stall_cnt), AW'(m_stall));
    chk("refill_addr", refill_addr, m_line);

    if (rst) begin
      chk("rst_pc_next", pc_next, '0);
    end else begin
      if (!m_in_miss) begin
        if (dcache_stall) begin
        end else if (branch_taken) begin
          e_pw = 1; e_next = branch_target; e_iff = 1; e_ief = 1; chk_ifw = 0;
        end else if (!icache_hit) begin
          e_iff = 1; start = 1;
        end else if (load_use) begin
          e_ief = 1;
        end else begin
          e_pw = 1; e_next = pc_cur + 4; e_ifw = 1;
        end
      end else begin
        chk_ifw = 0;
        e_iff = 1;
        e_ief = br_ok;
        if (m_age > 0 && refill_ack) begin
          finish = 1;
          if (br_ok) begin
            e_pw = 1; e_next = branch_target;
          end else if (redir_q.size() > 0) begin
            e_pw = 1; e_next = redir_q[$];
          end
        end else begin
          e_req = 1;
          if (br_ok) redir_q.push_back(branch_target);
        end
      end
      if (e_pw) chk("pc_next", pc_next, e_next);
    end

    chk("pc_write", AW'(pc_write), AW'(e_pw));
    chk("pc_stall", AW'(pc_stall), AW'(!e_pw));
    chk("ifid_flush", AW'(ifid_flush), AW'(e_iff));
    chk("idex_flush", AW'(idex_flush), AW'(e_ief));
    chk("refill_req", AW'(refill_req), AW'(e_req));
    if (chk_ifw) chk("ifid_write", AW'(ifid_write), AW'(e_ifw));

    if (rst) begin
      m_in_miss = 0; m_age = 0; m_line = '0; m_miss = 0; m_stall = 0;
      redir_q.delete();
    end else begin
      if (!e_pw && m_stall < SAT) m_stall++;
      if (m_in_miss && !finish) m_age++;
      if (finish) begin
        m_in_miss = 0;
        redir_q.delete();
      end
      if (start) begin
        m_in_miss = 1; m_age = 0;
        m_line = {pc_cur[AW-1:4], 4'h0};
        if (m_miss < SAT) m_miss++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [AW-1:0] pc, input logic hit, input logic ack,
                        input logic ds, input logic lu, input logic br,
                        input logic [AW-1:0] tgt);
    pc_cur = pc; icache_hit = hit; refill_ack = ack; dcache_stall = ds;
    load_use = lu; branch_taken = br; branch_target = tgt;
  endtask

  task automatic to_neg();
    @(negedge clk); #1;
  endtask

  task automatic to_pos();
    @(posedge clk); #1;
  endtask

  task automatic cyc();
    to_neg(); to_pos();
  endtask

  initial begin
    logic [AW-1:0] pc_r, tgt_r;
    logic          hit_r, ack_r, ds_r, lu_r, br_r;

    rst = 1'b1;
    set_in(32'h100, 1, 0, 0, 0, 0, 32'h0);
    cyc(); cyc();
    rst = 1'b0;

    // reset in the middle of a refill, then a late ack
    set_in(32'h20C, 0, 0, 0, 0, 0, 32'h0); cyc();
    set_in(32'h20C, 1, 0, 0, 0, 0, 32'h0); cyc(); cyc(); cyc();
    rst = 1'b1; cyc(); cyc();
    rst = 1'b0;
    set_in(32'h20C, 1, 1, 0, 0, 0, 32'h0);
    to_neg();
    chk("t1_refill_req", AW'(refill_req), 0);
    chk("t1_miss_cnt", AW'(miss_cnt), 0);
    chk("t1_stall_cnt", AW'(stall_cnt), 0);
    chk("t1_pc_write", AW'(pc_write), 1);
    to_pos();

    // steady hits
    set_in(32'h100, 1, 0, 0, 0, 0, 32'h0); cyc(); cyc();
    to_neg();
    chk("t2_pc_next", pc_next, 32'h104);
    chk("t2_ifid_write", AW'(ifid_write), 1);
    chk("t2_stall_cnt", AW'(stall_cnt), 0);
    to_pos();
    set_in(32'hFFFF_FFFC, 1, 0, 0, 0, 0, 32'h0);
    to_neg(); chk("t2_wrap", pc_next, 32'h0); to_pos();

    // miss at 0x20C, five waiting cycles, then ack
    set_in(32'h20C, 0, 0, 0, 0, 0, 32'h0);
    to_neg(); chk("t3_miss_flush", AW'(ifid_flush), 1); to_pos();
    set_in(32'h20C, 1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      to_neg();
      chk("t3_req", AW'(refill_req), 1);
      chk("t3_addr", refill_addr, 32'h200);
      to_pos();
    end
    set_in(32'h20C, 1, 1, 0, 0, 0, 32'h0);
    to_neg(); chk("t3_ack_req", AW'(refill_req), 0); to_pos();
    set_in(32'h20C, 1, 0, 0, 0, 0, 32'h0);
    to_neg();
    chk("t3_resume", pc_next, 32'h210);
    chk("t3_miss_cnt", AW'(miss_cnt), 1);
    chk("t3_stall_cnt", AW'(stall_cnt), 8);
    to_pos();

    // branch during the refill wait, redirect on ack
    set_in(32'h300, 0, 0, 0, 0, 0, 32'h0); cyc();
    set_in(32'h300, 1, 0, 0, 0, 0, 32'h0); cyc();
    set_in(32'h300, 1, 0, 0, 0, 1, 32'h400);
    to_neg();
    chk("t4_idex_flush", AW'(idex_flush), 1);
    chk("t4_hold", AW'(pc_write), 0);
    to_pos();
    set_in(32'h300, 1, 0, 0, 0, 0, 32'h0); cyc();
    set_in(32'h300, 1, 1, 0, 0, 0, 32'h0);
    to_neg();
    chk("t4_ack_pw", AW'(pc_write), 1);
    chk("t4_ack_next", pc_next, 32'h400);
    to_pos();
    set_in(32'h400, 1, 0, 0, 0, 0, 32'h0);
    to_neg(); chk("t4_after", pc_next, 32'h404); to_pos();

    // freeze beats branch and load-use; then the branch goes through
    set_in(32'h404, 1, 0, 1, 1, 1, 32'h500);
    to_neg();
    chk("t5_pw", AW'(pc_write), 0);
    chk("t5_iff", AW'(ifid_flush), 0);
    chk("t5_ief", AW'(idex_flush), 0);
    to_pos();
    set_in(32'h404, 1, 0, 0, 1, 1, 32'h500);
    to_neg();
    chk("t5_next", pc_next, 32'h500);
    chk("t5_iff2", AW'(ifid_flush), 1);
    chk("t5_ief2", AW'(idex_flush), 1);
    to_pos();

    // load-use bubble, then counter saturation
    set_in(32'h80, 1, 0, 0, 1, 0, 32'h0);
    to_neg();
    chk("t6_pw", AW'(pc_write), 0);
    chk("t6_ifw", AW'(ifid_write), 0);
    chk("t6_ief", AW'(idex_flush), 1);
    to_pos();
    set_in(32'h80, 1, 0, 0, 0, 0, 32'h0);
    to_neg(); chk("t6_next", pc_next, 32'h84); to_pos();
    set_in(32'h80, 1, 0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 20; i++) cyc();
    set_in(32'h80, 1, 0, 0, 0, 0, 32'h0);
    to_neg(); chk("t6_sat", AW'(stall_cnt), SAT); to_pos();

    rst = 1'b1; cyc(); rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      pc_r  = $urandom & 32'hFFFF_FFFC;
      tgt_r = $urandom & 32'hFFFF_FFFC;
      hit_r = ($urandom_range(0, 7) != 0);
      ds_r  = ($urandom_range(0, 5) == 0);
      br_r  = ($urandom_range(0, 6) == 0);
      lu_r  = ($urandom_range(0, 4) == 0);
      ack_r = ($urandom_range(0, 3) == 0);
      if (ack_r) begin
        br_r = 0; ds_r = 0;
      end
      set_in(pc_r, hit_r, ack_r, ds_r, lu_r, br_r, tgt_r);
      cyc();
    end

    to_neg();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
